// File: rtl/fm_sb_wr_serializer.sv
// fm_sb_wr_serializer
// Write-side front end of one fast-monitor spy buffer. A monitor record is
// latched and written LSW-first as AXI_DW-bit words into a circular log in the
// spy buffer memory. It also reports freeze, wrap and drop status.
// Optional build macro FM_SB_SKID_EN adds a one-entry skid register. The skid
// holds a record that arrives mid-serialization, so it is not dropped.
module fm_sb_wr_serializer #(
    parameter int MON_DW = 256,
    parameter int SB_DW  = 128,
    parameter int AXI_DW = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MON_DW-1:0] fm_data,
    input  logic              fm_vld,
    input  logic              freeze,
    input  logic              sb_clr,
    output logic              sb_we,
    output logic [ADDR_W-1:0] sb_addr,
    output logic [AXI_DW-1:0] sb_wdata,
    output logic              busy,
    output logic              frozen,
    output logic              wrapped,
    output logic [15:0]       drop_cnt
);

    localparam int N     = SB_DW / AXI_DW;
    localparam int DEPTH = ((1 << ADDR_W) / N) * N;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, SER, FROZEN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    wordIdx_q, wordIdx_d, nextIdx;
    logic [SB_DW-1:0]    rec_q, rec_d;
    logic                sb_we_q, sb_we_d;
    logic [ADDR_W-1:0]   sb_addr_q, sb_addr_d;
    logic [AXI_DW-1:0]   sb_wdata_q, sb_wdata_d;
    logic                busy_q, frozen_q;
    logic                wrapped_q, wrapped_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                lastWord, startNew, advance, dropHit;
`ifdef FM_SB_SKID_EN
    logic [SB_DW-1:0]    skid_q, skid_d;
    logic                skidFull_q, skidFull_d;
    logic                startSkid, skidLoad;
`endif

    // Upper monitor bits beyond this buffer's record width are intentionally ignored.
    generate
        if (MON_DW > SB_DW) begin : gHiBits
            logic unusedHiBits;
            assign unusedHiBits = ^fm_data[MON_DW-1:SB_DW];
        end
    endgenerate

    // State and datapath registers; sb_clr is handled in the next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wordIdx_q  <= '0;
            rec_q      <= '0;
            sb_we_q    <= 1'b0;
            sb_addr_q  <= '0;
            sb_wdata_q <= '0;
            busy_q     <= 1'b0;
            frozen_q   <= 1'b0;
            wrapped_q  <= 1'b0;
            drop_cnt_q <= '0;
`ifdef FM_SB_SKID_EN
            skid_q     <= '0;
            skidFull_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wordIdx_q  <= wordIdx_d;
            rec_q      <= rec_d;
            sb_we_q    <= sb_we_d;
            sb_addr_q  <= sb_addr_d;
            sb_wdata_q <= sb_wdata_d;
            busy_q     <= (state_d == SER);
            frozen_q   <= (state_d == FROZEN);
            wrapped_q  <= wrapped_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef FM_SB_SKID_EN
            skid_q     <= skid_d;
            skidFull_q <= skidFull_d;
`endif
        end
    end

    // Next-state logic: record acceptance, freeze handling and drop decisions.
    always_comb begin
        state_d   = state_q;
        startNew  = 1'b0;
        advance   = 1'b0;
        dropHit   = 1'b0;
`ifdef FM_SB_SKID_EN
        startSkid = 1'b0;
        skidLoad  = 1'b0;
`endif
        lastWord  = (state_q == SER) && (wordIdx_q == LAST_IDX);
        if (sb_clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (freeze) begin
                        state_d = FROZEN;
                    end else if (fm_vld) begin
                        startNew = 1'b1;
                        state_d  = SER;
                    end
                end
                SER: begin
                    if (!lastWord) begin
                        advance = 1'b1;
`ifdef FM_SB_SKID_EN
                        if (fm_vld) begin
                            if (skidFull_q) dropHit = 1'b1;
                            else            skidLoad = 1'b1;
                        end
`else
                        dropHit = fm_vld;
`endif
                    end
`ifdef FM_SB_SKID_EN
                    else if (skidFull_q) begin
                        startSkid = 1'b1;
                        skidLoad  = fm_vld && !freeze;
                    end
`endif
                    else if (freeze) begin
                        state_d = FROZEN;
                    end else if (fm_vld) begin
                        startNew = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FROZEN: begin
                    if (!freeze) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: next values of the memory write port, pointer and status.
    always_comb begin
        wordIdx_d  = wordIdx_q;
        rec_d      = rec_q;
        sb_we_d    = 1'b0;
        sb_addr_d  = sb_addr_q;
        sb_wdata_d = sb_wdata_q;
        wrapped_d  = wrapped_q;
        drop_cnt_d = drop_cnt_q;
        nextIdx    = wordIdx_q + IDX_W'(1);
`ifdef FM_SB_SKID_EN
        skid_d     = skid_q;
        skidFull_d = skidFull_q;
`endif
        if (sb_clr) begin
            wordIdx_d  = '0;
            rec_d      = '0;
            sb_addr_d  = '0;
            sb_wdata_d = '0;
            wrapped_d  = 1'b0;
            drop_cnt_d = '0;
`ifdef FM_SB_SKID_EN
            skid_d     = '0;
            skidFull_d = 1'b0;
`endif
        end else begin
            if (sb_we_q) begin
                if (sb_addr_q == LAST_ADDR) begin
                    sb_addr_d = '0;
                    wrapped_d = 1'b1;
                end else begin
                    sb_addr_d = sb_addr_q + ADDR_W'(1);
                end
            end
            if (startNew) begin
                rec_d      = fm_data[SB_DW-1:0];
                wordIdx_d  = '0;
                sb_we_d    = 1'b1;
                sb_wdata_d = fm_data[AXI_DW-1:0];
            end
`ifdef FM_SB_SKID_EN
            else if (startSkid) begin
                rec_d      = skid_q;
                wordIdx_d  = '0;
                sb_we_d    = 1'b1;
                sb_wdata_d = skid_q[AXI_DW-1:0];
            end
`endif
            else if (advance) begin
                wordIdx_d  = nextIdx;
                sb_we_d    = 1'b1;
                sb_wdata_d = rec_q[int'(nextIdx)*AXI_DW +: AXI_DW];
            end
`ifdef FM_SB_SKID_EN
            if (skidLoad) begin
                skid_d     = fm_data[SB_DW-1:0];
                skidFull_d = 1'b1;
            end else if (startSkid) begin
                skidFull_d = 1'b0;
            end
`endif
            if (dropHit && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    assign sb_we    = sb_we_q;
    assign sb_addr  = sb_addr_q;
    assign sb_wdata = sb_wdata_q;
    assign busy     = busy_q;
    assign frozen   = frozen_q;
    assign wrapped  = wrapped_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/fm_sb_wr_serializer.md
Name: fm_sb_wr_serializer

Overview:
- Write-side front end of one fast-monitor spy buffer. Captures a wide monitor record (fm_data/fm_vld, as produced by a user-logic FM tap) and serializes it into AXI_DW-bit words.
- Words are written into that spy buffer's memory write port (SB_MEM) as a circular record log.
- Sits between the FM tap mux and the spy buffer RAM; one instance per mapped spy buffer, including the dummy.
- Provides freeze, clear, wrap and drop-count status for FM_MON.

Parameters:
- MON_DW, 256, width of fm_data bus (mon_dw_max).
- SB_DW, 128, record width stored by this spy buffer; multiple of AXI_DW, ≤ MON_DW.
- AXI_DW, 32, memory word width.
- ADDR_W, 10, spy buffer word-address width.
- Derived: N = SB_DW/AXI_DW words per record; DEPTH = floor(2^ADDR_W / N)*N.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- fm_data  in  MON_DW  monitor record; bits [SB_DW-1:0] used.
- fm_vld  in  1  record valid, single-cycle qualifier.
- freeze  in  1  level; stop capture after current record.
- sb_clr  in  1  pulse; abort, clear pointer and status.
- sb_we  out  1  memory write enable.
- sb_addr  out  ADDR_W  memory word address.
- sb_wdata  out  AXI_DW  memory write data.
- busy  out  1  state==SER.
- frozen  out  1  state==FROZEN.
- wrapped  out  1  sticky: address has wrapped at least once.
- drop_cnt  out  16  saturating count of rejected records.

Behaviour:
- Reset (async, rst=1): state IDLE; sb_we=0, sb_addr=0, sb_wdata=0, busy=0, frozen=0, wrapped=0, drop_cnt=0; word index and latched record cleared.
- States: IDLE, SER, FROZEN.
  - IDLE: fm_vld & !freeze → latch fm_data[SB_DW-1:0], go SER. freeze & !fm_vld → FROZEN. fm_vld & freeze → record ignored, not counted, go FROZEN.
  - SER: one word per cycle, LSW first; word k = rec[k*AXI_DW +: AXI_DW].
  - After the last word: freeze → FROZEN; accepted fm_vld in the last-word cycle → SER again; else IDLE.
  - FROZEN: no writes; fm_vld ignored, not counted. freeze=0 → IDLE.
- Latency: fm_vld at cycle t → sb_we=1 at t+1..t+N; word k at t+1+k with sb_addr = base+k. All outputs registered.
- Throughput: fm_vld in the last-word cycle (t+N) is accepted; back-to-back writes continue seamlessly, giving one record per N cycles. N=1 accepts fm_vld every cycle.
- fm_vld in SER other than the last-word cycle → record dropped; drop_cnt +1, saturating at 16'hFFFF.
- Address: sb_addr increments after each write. When it would reach DEPTH it wraps to 0 and wrapped is set (sticky). Records never straddle the wrap.
- freeze asserted mid-record: the current record always completes. freeze deasserted before record end → no effect.
- sb_clr: highest priority, any state. Next cycle: sb_we=0, state IDLE, sb_addr=0, wrapped=0, drop_cnt=0. A partial record is abandoned. fm_vld coincident with sb_clr is ignored.
- rst mid-record: immediate async clear; no further writes.

Optional Feature:
- FM_SB_SKID_EN defined: a one-entry skid register.
  - fm_vld during SER when not in the last-word cycle is held in the skid, not dropped.
  - The skid record starts at the cycle after the current last word, contiguous in address.
  - fm_vld while the skid is full and not in the last-word cycle → drop_cnt +1.
  - A pending skid record is written before entering FROZEN.
  - sb_clr empties the skid.
- Undefined: no skid; drop rule as in Behaviour.

Test Plan (MON_DW=256, SB_DW=128, N=4, ADDR_W=4, DEPTH=16):
- Single record: fm_vld at t0 with data 128'h44444444_33333333_22222222_11111111 → sb_we t1..t4, sb_addr 0,1,2,3, sb_wdata 11111111, 22222222, 33333333, 44444444; busy t1..t4.
- Wrap: 5 records spaced 6 cycles → 5th written at addr 0..3; wrapped=1 from its first write; 4th occupied 12..15.
- Drop/throughput (no skid): fm_vld t0,t2 → drop_cnt=1, 4 writes only. fm_vld t0,t4 → 8 contiguous writes t1..t8, addr 0..7, drop_cnt=0.
- Freeze: fm_vld t0, freeze=1 from t2 → writes addr 0..3 complete, frozen=1 at t5. fm_vld at t8 → no write, drop_cnt=0. freeze=0 then fm_vld → writes at addr 4..7.
- Clear/reset: sb_clr at t2 of a record → no sb_we from t3, sb_addr=0, drop_cnt=0, wrapped=0. rst at t2 → all outputs 0 immediately.
- FM_SB_SKID_EN: fm_vld t0,t1 → 8 contiguous writes t1..t8, addr 0..7. fm_vld t0,t1,t2 → drop_cnt=1. freeze at t2 with skid full → 8 writes, then frozen=1.
